// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    localparam logic [3:0] ROW_IDLE = 4'b1111;
    localparam logic [3:0] ROW0     = 4'b1110;
    localparam logic [3:0] COL_IDLE = 4'b1111;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } col_hit_t;

    // Exactly one low column is a key; none or several low is "no key".
    function automatic col_hit_t onehot_low_idx(input logic [3:0] cols);
        col_hit_t hit;
        case (cols)
            4'b1110: hit = {1'b1, 2'd0};
            4'b1101: hit = {1'b1, 2'd1};
            4'b1011: hit = {1'b1, 2'd2};
            4'b0111: hit = {1'b1, 2'd3};
            default: hit = {1'b0, 2'd0};
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Free-running SCAN_DIV-bit divider; tick_c is high for the one clk where the count is all-ones.
module scan_tick #(
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick_c
);

    logic [SCAN_DIV-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + SCAN_DIV'(1);
        end
    end

    assign tick_c = &cnt;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row strobe, column sync, press/release debounce, one code per press.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 16,
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned REPEAT_TICKS   = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int unsigned MAX_TICKS = (DEBOUNCE_TICKS > REPEAT_TICKS) ? DEBOUNCE_TICKS : REPEAT_TICKS;
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS) + 1;
    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_TICKS);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t           state, state_nxt;
    logic             tick, accept;
    logic [3:0]       col_meta, col_sync;
    logic [3:0]       pat, pat_nxt;
    logic [1:0]       row_idx, row_idx_nxt;
    logic [3:0]       row_out_nxt, key_code_nxt;
    logic             key_valid_nxt, key_down_nxt;
    logic [CNT_W-1:0] dbcnt, dbcnt_nxt, relcnt, relcnt_nxt;
    col_hit_t         col_hit;
`ifdef KEYPAD_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LIMIT = CNT_W'(REPEAT_TICKS);
    logic [CNT_W-1:0] rptcnt, rptcnt_nxt;
`endif

    scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_c (tick)
    );

    // Two-flop synchronizer for the asynchronous column returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta <= COL_IDLE;
            col_sync <= COL_IDLE;
        end else begin
            col_meta <= col_in;
            col_sync <= col_meta;
        end
    end

    assign col_hit     = onehot_low_idx(col_sync);
    assign row_out_nxt = ROW_IDLE ^ (4'b0001 << row_idx_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            row_out   <= ROW0;
            pat       <= COL_IDLE;
            dbcnt     <= '0;
            relcnt    <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rptcnt    <= '0;
`endif
        end else begin
            state     <= state_nxt;
            row_idx   <= row_idx_nxt;
            row_out   <= row_out_nxt;
            pat       <= pat_nxt;
            dbcnt     <= dbcnt_nxt;
            relcnt    <= relcnt_nxt;
            key_code  <= key_code_nxt;
            key_valid <= key_valid_nxt;
            key_down  <= key_down_nxt;
`ifdef KEYPAD_REPEAT_EN
            rptcnt    <= rptcnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        row_idx_nxt   = row_idx;
        pat_nxt       = pat;
        dbcnt_nxt     = dbcnt;
        relcnt_nxt    = relcnt;
        key_code_nxt  = key_code;
        key_valid_nxt = 1'b0;
        key_down_nxt  = key_down;
        accept        = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rptcnt_nxt    = rptcnt;
`endif
        if (tick) begin
            case (state)
                SCAN: begin
                    if (col_hit.valid) begin
                        pat_nxt   = col_sync;
                        dbcnt_nxt = CNT_W'(1);
                        if (dbcnt_nxt >= DB_LIMIT) begin
                            accept = 1'b1;
                        end else begin
                            state_nxt = DEBOUNCE;
                        end
                    end else begin
                        row_idx_nxt = row_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    // A mismatch drops back to SCAN on the same row so it is re-sampled next tick.
                    if (col_sync == pat) begin
                        dbcnt_nxt = sat_inc(dbcnt);
                        if (dbcnt_nxt >= DB_LIMIT) begin
                            accept = 1'b1;
                        end
                    end else begin
                        state_nxt = SCAN;
                        dbcnt_nxt = '0;
                    end
                end
                PRESSED: begin
                    relcnt_nxt = (col_sync == COL_IDLE) ? sat_inc(relcnt) : '0;
                    if (relcnt_nxt >= DB_LIMIT) begin
                        state_nxt    = SCAN;
                        key_down_nxt = 1'b0;
                        relcnt_nxt   = '0;
                        row_idx_nxt  = row_idx + 2'd1;
                    end
`ifdef KEYPAD_REPEAT_EN
                    if (col_sync == pat) begin
                        rptcnt_nxt = sat_inc(rptcnt);
                        if (rptcnt_nxt >= RPT_LIMIT) begin
                            rptcnt_nxt    = '0;
                            key_valid_nxt = 1'b1;
                        end
                    end else begin
                        rptcnt_nxt = '0;
                    end
`endif
                end
                default: state_nxt = SCAN;
            endcase
        end
        // On acceptance col_sync equals the latched pattern, so its index is the key column.
        if (accept) begin
            state_nxt     = PRESSED;
            key_code_nxt  = {row_idx, col_hit.idx};
            key_valid_nxt = 1'b1;
            key_down_nxt  = 1'b1;
            dbcnt_nxt     = '0;
            relcnt_nxt    = '0;
`ifdef KEYPAD_REPEAT_EN
            rptcnt_nxt    = '0;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a physical 4x4 key-matrix model drives col_in from row_out and held keys.
module tb_keypad_scan;

    localparam int unsigned SCAN_DIV       = 2;
    localparam int unsigned DEBOUNCE_TICKS = 3;
    localparam int unsigned REPEAT_TICKS   = 5;
    localparam int TICK_CLKS = 4;
    localparam int REL_CLKS  = TICK_CLKS * DEBOUNCE_TICKS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [15:0] keys = '0;
    logic [3:0]  rows [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    int   checks = 0;
    int   errors = 0;
    int   vcount = 0;
    logic [3:0] last_code = 4'd0;
    bit   prev_valid = 1'b0;
    bit   double_pulse = 1'b0;

    keypad_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .REPEAT_TICKS   (REPEAT_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    // Key matrix: a held key pulls its column low while its row is strobed.
    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            vcount++;
            last_code = key_code;
        end
        if (key_valid && prev_valid) double_pulse = 1'b1;
        prev_valid = key_valid;
    end

    function automatic int exp_pulses(input int hold_ticks);
`ifdef KEYPAD_REPEAT_EN
        return 1 + hold_ticks / int'(REPEAT_TICKS);
`else
        return 1 + 0 * hold_ticks;
`endif
    endfunction

    task automatic wait_down(input logic lvl, input int limit, output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (key_down === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Waits for a fresh arrival of row_out at target (just after the tick that selected it).
    task automatic wait_row(input logic [3:0] target, input int limit, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (row_out === target && n < limit) begin
            @(negedge clk);
            n++;
        end
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (row_out === target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b1;
        keys = '0;
        repeat (3) @(negedge clk);
        checks++; if (row_out !== 4'b1110) begin errors++; $display("FAIL reset_row_out: got %b expected 1110", row_out); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL reset_key_down: got %b expected 0", key_down); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_key_code: got %h expected 0", key_code); end
        rst = 1'b0;
        wait_row(4'b1011, 10 * TICK_CLKS, ok);
        checks++; if (!ok) begin errors++; $display("FAIL reset_scan_reach_row2: got timeout expected row 1011"); end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (row_out !== 4'b1110) begin errors++; $display("FAIL async_reset_row_out: got %b expected 1110", row_out); end
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL async_reset_key_down: got %b expected 0", key_down); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_scan_rotate();
        logic [3:0] prev;
        int changes = 0;
        prev = row_out;
        for (int i = 0; i < 6 * TICK_CLKS; i++) begin
            @(negedge clk);
            if (row_out !== prev) begin
                logic [3:0] exp_row;
                exp_row = 4'bxxxx;
                for (int r = 0; r < 4; r++) if (rows[r] === prev) exp_row = rows[(r + 1) % 4];
                checks++;
                if (row_out !== exp_row) begin errors++; $display("FAIL scan_rotate: got %b expected %b", row_out, exp_row); end
                changes++;
                prev = row_out;
            end
        end
        checks++; if (changes < 5) begin errors++; $display("FAIL scan_rotate_count: got %0d expected >=5", changes); end
    endtask

    task automatic test_presses();
        int  klist [10];
        int  hlist [10];
        int  n, v0, k, exp_n;
        bit  ok;
        klist[0] = 6;  hlist[0] = 0;
        klist[1] = 15; hlist[1] = 12;
        for (int i = 2; i < 10; i++) begin
            klist[i] = int'($urandom_range(15, 0));
            hlist[i] = int'($urandom_range(14, 0));
        end
        for (int i = 0; i < 10; i++) begin
            k = klist[i];
            v0 = vcount;
            keys = 16'(1) << k;
            wait_down(1'b1, 40 * TICK_CLKS, n, ok);
            checks++; if (!ok) begin errors++; $display("FAIL press_accept key %0d: got timeout expected key_down=1", k); end
            repeat (hlist[i] * TICK_CLKS) @(negedge clk);
            keys = '0;
            wait_down(1'b0, 20 * TICK_CLKS, n, ok);
            checks++;
            if (!ok || n != REL_CLKS) begin errors++; $display("FAIL release_time key %0d: got %0d clks expected %0d", k, n, REL_CLKS); end
            checks++;
            if (row_out !== rows[(k / 4 + 1) % 4]) begin errors++; $display("FAIL release_row key %0d: got %b expected %b", k, row_out, rows[(k / 4 + 1) % 4]); end
            checks++; if (key_code !== 4'(k)) begin errors++; $display("FAIL key_code: got %h expected %h", key_code, 4'(k)); end
            repeat (2) @(negedge clk);
            exp_n = exp_pulses(hlist[i]);
            checks++; if (vcount - v0 != exp_n) begin errors++; $display("FAIL pulse_count key %0d hold %0d: got %0d expected %0d", k, hlist[i], vcount - v0, exp_n); end
            checks++; if (last_code !== 4'(k)) begin errors++; $display("FAIL pulse_code: got %h expected %h", last_code, 4'(k)); end
        end
        checks++; if (double_pulse !== 1'b0) begin errors++; $display("FAIL key_valid_width: got multi-clk pulse expected 1 clk"); end
    endtask

    task automatic test_bounce();
        int  k, b, v0, n;
        bit  ok;
        for (int i = 0; i < 4; i++) begin
            k = (i == 0) ? 12 : int'($urandom_range(15, 0));
            b = (i == 0) ? 2 : int'($urandom_range(2, 1));
            v0 = vcount;
            wait_row(rows[k / 4], 10 * TICK_CLKS, ok);
            checks++; if (!ok) begin errors++; $display("FAIL bounce_row_wait: got timeout expected %b", rows[k / 4]); end
            keys = 16'(1) << k;
            repeat (b * TICK_CLKS) @(negedge clk);
            keys = '0;
            repeat (TICK_CLKS) @(negedge clk);
            checks++; if (row_out !== rows[k / 4]) begin errors++; $display("FAIL bounce_row_held key %0d: got %b expected %b", k, row_out, rows[k / 4]); end
            repeat (TICK_CLKS) @(negedge clk);
            checks++; if (row_out !== rows[(k / 4 + 1) % 4]) begin errors++; $display("FAIL bounce_row_resume key %0d: got %b expected %b", k, row_out, rows[(k / 4 + 1) % 4]); end
            checks++; if (vcount != v0 || key_down !== 1'b0) begin errors++; $display("FAIL bounce_no_key key %0d: got %0d pulses down=%b expected 0 pulses down=0", k, vcount - v0, key_down); end
        end
        keys = 16'(1) << 12;
        wait_down(1'b1, 40 * TICK_CLKS, n, ok);
        checks++; if (!ok || key_code !== 4'hC) begin errors++; $display("FAIL bounce_then_press: got %h ok=%0d expected c", key_code, ok); end
        keys = '0;
        wait_down(1'b0, 20 * TICK_CLKS, n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bounce_then_release: got timeout expected key_down=0"); end
    endtask

    task automatic test_multi_key();
        logic [3:0] seen;
        int  v0, n, r, a, b;
        bit  ok;
        seen = '0;
        v0 = vcount;
        keys = 16'h0003;
        for (int i = 0; i < 8 * TICK_CLKS; i++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) if (row_out === rows[j]) seen[j] = 1'b1;
        end
        keys = '0;
        checks++; if (seen !== 4'b1111) begin errors++; $display("FAIL multi_rows_rotate: got %b expected 1111", seen); end
        checks++; if (vcount != v0 || key_down !== 1'b0) begin errors++; $display("FAIL multi_no_key: got %0d pulses expected 0", vcount - v0); end
        r = int'($urandom_range(3, 0));
        a = int'($urandom_range(3, 0));
        b = (a + int'($urandom_range(3, 1))) % 4;
        repeat (2 * TICK_CLKS) @(negedge clk);
        v0 = vcount;
        keys = 16'(1) << (r * 4 + a);
        wait_down(1'b1, 40 * TICK_CLKS, n, ok);
        keys = keys | (16'(1) << (r * 4 + b));
        repeat (8 * TICK_CLKS) @(negedge clk);
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL second_key_down: got %b expected 1", key_down); end
        keys = '0;
        wait_down(1'b0, 20 * TICK_CLKS, n, ok);
        repeat (2) @(negedge clk);
        checks++; if (vcount - v0 != 1) begin errors++; $display("FAIL second_key_pulses: got %0d expected 1", vcount - v0); end
        checks++; if (key_code !== 4'(r * 4 + a)) begin errors++; $display("FAIL second_key_code: got %h expected %h", key_code, 4'(r * 4 + a)); end
    endtask

    task automatic test_release_bounce();
        int  k, v0, n;
        bit  ok;
        k = int'($urandom_range(3, 0)) * 4 + 1;
        v0 = vcount;
        keys = 16'(1) << k;
        wait_down(1'b1, 40 * TICK_CLKS, n, ok);
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? 16'(0) : 16'(1) << k;
            repeat (TICK_CLKS) @(negedge clk);
        end
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL release_bounce_held: got %b expected 1", key_down); end
        keys = '0;
        wait_down(1'b0, 20 * TICK_CLKS, n, ok);
        checks++; if (!ok || n != REL_CLKS) begin errors++; $display("FAIL release_bounce_time: got %0d clks expected %0d", n, REL_CLKS); end
        repeat (2) @(negedge clk);
        checks++; if (vcount - v0 != 1) begin errors++; $display("FAIL release_bounce_pulses: got %0d expected 1", vcount - v0); end
    endtask

    task automatic test_reset_pressed();
        int  k, n;
        bit  ok;
        k = int'($urandom_range(15, 1));
        keys = 16'(1) << k;
        wait_down(1'b1, 40 * TICK_CLKS, n, ok);
        checks++; if (!ok || key_code !== 4'(k)) begin errors++; $display("FAIL pre_reset_press: got %h expected %h", key_code, 4'(k)); end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL pressed_reset_key_down: got %b expected 0", key_down); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL pressed_reset_key_code: got %h expected 0", key_code); end
        checks++; if (row_out !== 4'b1110 && k / 4 != 0) begin errors++; $display("FAIL pressed_reset_row_out: got %b expected 1110", row_out); end
        keys = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan_rotate();
        test_presses();
        test_bounce();
        test_multi_key();
        test_release_bounce();
        test_reset_pressed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
